spmv_mem_arbiter: RTL and testbench
===================================

SPMV_MEM_ARBITER -- requirements
Module: spmv_mem_arbiter

Interface
REQ-001 SHALL have parameters: STARVE_LIMIT, default 16, max consecutive denied cycles for a pending decoder load; MAX_OUTSTANDING, default 32, max in-flight loads.
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port cfg_load, input, 1, loads store window.
REQ-005 SHALL have ports cfg_base and cfg_end, input, 48 each, store window start and end byte address.
REQ-006 SHALL have ports st_valid (input, 1), st_data (input, 64) and st_ready (output, 1), the MAC result store requester.
REQ-007 SHALL have ports cl_valid (input, 1), cl_addr (input, 48) and cl_ready (output, 1), the x-cache load requester.
REQ-008 SHALL have ports dl_valid (input, 1), dl_addr (input, 48), dl_tag (input, 2) and dl_ready (output, 1), the matrix decoder load requester.
REQ-009 SHALL have outputs req_mem_ld (1), req_mem_st (1), req_mem_addr (48) and req_mem_d_or_tag (64), all registered.
REQ-010 SHALL have port req_mem_stall, input, 1, memory backpressure.
REQ-011 SHALL have port rsp_mem_push, input, 1, one load response returned.
REQ-012 SHALL have outputs done (1, store window exhausted), outstanding (6, in-flight loads) and err (1, sticky response underflow).

Function
REQ-013 A transfer SHALL occur on a requester when valid && ready in the same cycle; each ready SHALL be combinational and at most one ready SHALL be high per cycle.
REQ-014 All readys SHALL be 0 while req_mem_stall=1.
REQ-015 Priority SHALL be store > cache load > decoder load, except as REQ-016 states.
REQ-016 A starve counter SHALL count consecutive cycles with dl_valid=1, dl_ready=0 and req_mem_stall=0; at STARVE_LIMIT the decoder SHALL win the next eligible cycle, and the counter SHALL clear on any decoder grant.
REQ-017 Loads (cache and decoder) SHALL be ineligible while outstanding == MAX_OUTSTANDING.
REQ-018 outstanding SHALL be +1 on a load grant and -1 on rsp_mem_push; when both occur in one cycle it SHALL be unchanged.
REQ-019 rsp_mem_push with outstanding=0 SHALL leave outstanding at 0 and set err.
REQ-020 Memory outputs SHALL register the granted request 1 cycle after the grant; with no grant, req_mem_ld=req_mem_st=0 and addr/data SHALL hold.
REQ-021 A cache grant SHALL issue req_mem_ld=1, addr=cl_addr and d_or_tag={61'b0,2'b00,1'b1}.
REQ-022 A decoder grant SHALL issue req_mem_ld=1, addr=dl_addr and d_or_tag={61'b0,dl_tag,1'b0}.
REQ-023 A store grant in RUN SHALL issue req_mem_st=1, addr=store pointer and d_or_tag=st_data, then advance the pointer by 8 (48-bit wrap).
REQ-024 The FSM SHALL have three states: IDLE, RUN and FULL.
REQ-025 IDLE SHALL hold st_ready=0 and done=0.
REQ-026 cfg_load in any state SHALL set pointer=cfg_base, end=cfg_end and go to RUN, or to FULL if cfg_base==cfg_end; cfg_load SHALL take precedence over a same-cycle store.
REQ-027 RUN SHALL go to FULL on the store grant where pointer+8 == end.
REQ-028 In FULL, done=1; stores SHALL still be granted by priority but dropped, with no req_mem_st.
REQ-029 Load arbitration SHALL be independent of FSM state.

Reset
REQ-030 While rst_n=0, asynchronously: state=IDLE; pointer=0; end=0; outstanding=0; starve counter=0; err=0; done=0; all readys=0; req_mem_ld=0; req_mem_st=0; req_mem_addr=0; req_mem_d_or_tag=0.
REQ-031 Reset asserted mid-operation SHALL discard in-flight accounting; responses after reset SHALL follow REQ-019.

Verification
REQ-032 cfg_base=0x1000, cfg_end=0x1018, then 4 stores -> req_mem_st at 0x1000, 0x1008, 0x1010; done=1 after the third; the fourth store is granted with no req_mem_st.
REQ-033 st_valid, cl_valid and dl_valid held high with no stall -> stores granted every cycle; dl granted on cycle 17 (STARVE_LIMIT=16); d_or_tag low 3 bits = {dl_tag,0}.
REQ-034 cl_valid held with no responses -> 32 ld issued, then cl_ready=0 with outstanding=32; one rsp_mem_push -> exactly one more ld.
REQ-035 req_mem_stall=1 for 5 cycles with all valid -> no readys and no req_mem_ld/st during the stall; the grant resumes the cycle stall drops.
REQ-036 rsp_mem_push with outstanding=0 -> err=1 sticky; rst_n pulse mid-store-burst -> all outputs 0 immediately, state IDLE.
REQ-037 cfg_base==cfg_end=0x2000 -> done=1 next cycle and zero stores issued.

Source files
------------

// File: rtl/spmv_mem_arbiter_if.sv
// Request/response bundle between the SpMV requesters, the store-window config and memory.
// The slave view belongs to the arbiter; the master view drives it.
interface spmv_mem_arbiter_if;
   logic        cfg_load;
   logic [47:0] cfg_base;
   logic [47:0] cfg_end;
   logic        st_valid;
   logic [63:0] st_data;
   logic        st_ready;
   logic        cl_valid;
   logic [47:0] cl_addr;
   logic        cl_ready;
   logic        dl_valid;
   logic [47:0] dl_addr;
   logic [1:0]  dl_tag;
   logic        dl_ready;
   logic        req_mem_ld;
   logic        req_mem_st;
   logic [47:0] req_mem_addr;
   logic [63:0] req_mem_d_or_tag;
   logic        req_mem_stall;
   logic        rsp_mem_push;
   logic        done;
   logic [5:0]  outstanding;
   logic        err;

   modport slave (
      input  cfg_load, cfg_base, cfg_end, st_valid, st_data, cl_valid, cl_addr,
             dl_valid, dl_addr, dl_tag, req_mem_stall, rsp_mem_push,
      output st_ready, cl_ready, dl_ready, req_mem_ld, req_mem_st, req_mem_addr,
             req_mem_d_or_tag, done, outstanding, err
   );

   modport master (
      output cfg_load, cfg_base, cfg_end, st_valid, st_data, cl_valid, cl_addr,
             dl_valid, dl_addr, dl_tag, req_mem_stall, rsp_mem_push,
      input  st_ready, cl_ready, dl_ready, req_mem_ld, req_mem_st, req_mem_addr,
             req_mem_d_or_tag, done, outstanding, err
   );
endinterface

// File: rtl/spmv_mem_arbiter.sv
// Memory-port arbiter for the SpMV engine: result stores, x-cache loads and decoder loads
// share one registered request port; stores walk a configured address window.
module spmv_mem_arbiter #(
   parameter int STARVE_LIMIT    = 16,
   parameter int MAX_OUTSTANDING = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   spmv_mem_arbiter_if.slave bus
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FULL = 2'd2
   } state_t;

   state_t        state_r;
   logic [47:0]   ptr_r;
   logic [47:0]   end_r;
   logic [SW-1:0] starve_r;
   logic [5:0]    out_r;
   logic          err_r;
   logic          done_r;
   logic          ld_r;
   logic          st_r;
   logic [47:0]   addr_r;
   logic [63:0]   data_r;

   logic          ld_ok_s;
   logic          starved_s;
   logic          st_ok_s;
   logic          st_gnt_s;
   logic          cl_gnt_s;
   logic          dl_gnt_s;
   logic          ld_gnt_s;
   logic [47:0]   ptr_next_s;

   // Single-winner grant; a starved decoder jumps ahead of stores and cache loads.
   always_comb begin
      ld_ok_s    = (out_r != 6'(MAX_OUTSTANDING));
      starved_s  = (starve_r == SW'(STARVE_LIMIT));
      st_ok_s    = bus.st_valid && (state_r != IDLE) && !bus.cfg_load;
      ptr_next_s = ptr_r + 48'd8;
      st_gnt_s   = 1'b0;
      cl_gnt_s   = 1'b0;
      dl_gnt_s   = 1'b0;
      if (!rst_n || bus.req_mem_stall) begin
         st_gnt_s = 1'b0;
      end else if (starved_s && bus.dl_valid && ld_ok_s) begin
         dl_gnt_s = 1'b1;
      end else if (st_ok_s) begin
         st_gnt_s = 1'b1;
      end else if (bus.cl_valid && ld_ok_s) begin
         cl_gnt_s = 1'b1;
      end else if (bus.dl_valid && ld_ok_s) begin
         dl_gnt_s = 1'b1;
      end else begin
         st_gnt_s = 1'b0;
      end
      ld_gnt_s = cl_gnt_s || dl_gnt_s;
   end

   // Store-window FSM together with the registered memory request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         ptr_r   <= 48'd0;
         end_r   <= 48'd0;
         done_r  <= 1'b0;
         ld_r    <= 1'b0;
         st_r    <= 1'b0;
         addr_r  <= 48'd0;
         data_r  <= 64'd0;
      end else begin
         ld_r <= ld_gnt_s;
         st_r <= st_gnt_s && (state_r == RUN);
         if (cl_gnt_s) begin
            addr_r <= bus.cl_addr;
            data_r <= {61'd0, 2'b00, 1'b1};
         end else if (dl_gnt_s) begin
            addr_r <= bus.dl_addr;
            data_r <= {61'd0, bus.dl_tag, 1'b0};
         end else if (st_gnt_s && (state_r == RUN)) begin
            addr_r <= ptr_r;
            data_r <= bus.st_data;
         end else begin
            addr_r <= addr_r;
            data_r <= data_r;
         end
         if (bus.cfg_load) begin
            ptr_r   <= bus.cfg_base;
            end_r   <= bus.cfg_end;
            state_r <= (bus.cfg_base == bus.cfg_end) ? FULL : RUN;
            done_r  <= (bus.cfg_base == bus.cfg_end);
         end else begin
            case (state_r)
               IDLE: done_r <= 1'b0;
               RUN: begin
                  if (st_gnt_s) begin
                     ptr_r <= ptr_next_s;
                     if (ptr_next_s == end_r) begin
                        state_r <= FULL;
                        done_r  <= 1'b1;
                     end else begin
                        done_r  <= 1'b0;
                     end
                  end else begin
                     done_r <= 1'b0;
                  end
               end
               FULL: done_r <= 1'b1;
               default: begin
                  state_r <= IDLE;
                  done_r  <= 1'b0;
               end
            endcase
         end
      end
   end

   // In-flight load count, sticky underflow flag and decoder starvation counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_r    <= 6'd0;
         err_r    <= 1'b0;
         starve_r <= '0;
      end else begin
         if (bus.rsp_mem_push && (out_r == 6'd0)) begin
            err_r <= 1'b1;
         end else begin
            err_r <= err_r;
         end
         if (ld_gnt_s && !bus.rsp_mem_push) begin
            out_r <= out_r + 6'd1;
         end else if (!ld_gnt_s && bus.rsp_mem_push && (out_r != 6'd0)) begin
            out_r <= out_r - 6'd1;
         end else begin
            out_r <= out_r;
         end
         // A gap in dl_valid ends the denied streak; stalled cycles neither count nor reset it.
         if (dl_gnt_s || !bus.dl_valid) begin
            starve_r <= '0;
         end else if (!bus.req_mem_stall && !starved_s) begin
            starve_r <= starve_r + SW'(1);
         end else begin
            starve_r <= starve_r;
         end
      end
   end

   assign bus.st_ready         = st_gnt_s;
   assign bus.cl_ready         = cl_gnt_s;
   assign bus.dl_ready         = dl_gnt_s;
   assign bus.req_mem_ld       = ld_r;
   assign bus.req_mem_st       = st_r;
   assign bus.req_mem_addr     = addr_r;
   assign bus.req_mem_d_or_tag = data_r;
   assign bus.done             = done_r;
   assign bus.outstanding      = out_r;
   assign bus.err              = err_r;
endmodule

// File: tb/tb_spmv_mem_arbiter.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_spmv_mem_arbiter;
   localparam int STARVE = 16;
   localparam int MAXO   = 32;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   spmv_mem_arbiter_if bus();

   spmv_mem_arbiter #(.STARVE_LIMIT(STARVE), .MAX_OUTSTANDING(MAXO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   int          m_mode;
   logic [47:0] m_ptr;
   logic [47:0] m_end;
   int          m_wait;
   int          m_q[$];
   logic        m_err;
   logic        m_ld;
   logic        m_st;
   logic [47:0] m_addr;
   logic [63:0] m_data;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.cfg_load = 1'b0; bus.cfg_base = 48'd0; bus.cfg_end = 48'd0;
      bus.st_valid = 1'b0; bus.st_data = 64'd0;
      bus.cl_valid = 1'b0; bus.cl_addr = 48'd0;
      bus.dl_valid = 1'b0; bus.dl_addr = 48'd0; bus.dl_tag = 2'd0;
      bus.req_mem_stall = 1'b0; bus.rsp_mem_push = 1'b0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic load_window(input logic [47:0] b, input logic [47:0] e);
      bus.cfg_load = 1'b1; bus.cfg_base = b; bus.cfg_end = e;
      tick();
      bus.cfg_load = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      bus.st_valid = 1'b1; bus.cl_valid = 1'b1; bus.dl_valid = 1'b1;
      #2;
      n_cmp++; if ({bus.st_ready, bus.cl_ready, bus.dl_ready} !== 3'b000) begin n_bad++; $display("FAIL reset_ready got %b exp 000", {bus.st_ready, bus.cl_ready, bus.dl_ready}); end
      n_cmp++; if ({bus.req_mem_ld, bus.req_mem_st, bus.done, bus.err} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags got %b exp 0000", {bus.req_mem_ld, bus.req_mem_st, bus.done, bus.err}); end
      n_cmp++; if (bus.req_mem_addr !== 48'd0 || bus.req_mem_d_or_tag !== 64'd0) begin n_bad++; $display("FAIL reset_bus got %h/%h exp 0/0", bus.req_mem_addr, bus.req_mem_d_or_tag); end
      n_cmp++; if (bus.outstanding !== 6'd0) begin n_bad++; $display("FAIL reset_outstanding got %0d exp 0", bus.outstanding); end
      apply_reset();
   endtask

   task automatic test_store_window();
      apply_reset();
      load_window(48'h1000, 48'h1018);
      n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL win_done_init got %b exp 0", bus.done); end
      bus.st_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.st_data = 64'hABCD_0000 + 64'(i);
         #1;
         n_cmp++; if (bus.st_ready !== 1'b1) begin n_bad++; $display("FAIL win_ready%0d got %b exp 1", i, bus.st_ready); end
         tick();
         n_cmp++; if (bus.req_mem_st !== (i < 3)) begin n_bad++; $display("FAIL win_st%0d got %b exp %b", i, bus.req_mem_st, (i < 3)); end
         if (i < 3) begin
            n_cmp++; if (bus.req_mem_addr !== 48'h1000 + 48'(8 * i) || bus.req_mem_d_or_tag !== 64'hABCD_0000 + 64'(i)) begin n_bad++; $display("FAIL win_addr%0d got %h/%h exp %h", i, bus.req_mem_addr, bus.req_mem_d_or_tag, 48'h1000 + 48'(8 * i)); end
         end
         n_cmp++; if (bus.done !== (i >= 2)) begin n_bad++; $display("FAIL win_done%0d got %b exp %b", i, bus.done, (i >= 2)); end
      end
      bus.st_valid = 1'b0;
   endtask

   task automatic test_starve();
      apply_reset();
      load_window(48'h0, 48'h10000);
      bus.st_valid = 1'b1; bus.cl_valid = 1'b1; bus.dl_valid = 1'b1;
      bus.dl_tag = 2'b10; bus.dl_addr = 48'hD00D; bus.cl_addr = 48'hC0C0;
      for (int c = 1; c <= 18; c++) begin
         #1;
         n_cmp++; if ({bus.st_ready, bus.cl_ready, bus.dl_ready} !== ((c == 17) ? 3'b001 : 3'b100)) begin n_bad++; $display("FAIL starve_ready c%0d got %b exp %b", c, {bus.st_ready, bus.cl_ready, bus.dl_ready}, ((c == 17) ? 3'b001 : 3'b100)); end
         tick();
         if (c == 17) begin
            n_cmp++; if (bus.req_mem_ld !== 1'b1 || bus.req_mem_d_or_tag[2:0] !== 3'b100 || bus.req_mem_addr !== 48'hD00D) begin n_bad++; $display("FAIL starve_issue got ld=%b tag=%b addr=%h exp 1/100/d00d", bus.req_mem_ld, bus.req_mem_d_or_tag[2:0], bus.req_mem_addr); end
            n_cmp++; if (bus.outstanding !== 6'd1) begin n_bad++; $display("FAIL starve_out got %0d exp 1", bus.outstanding); end
         end
      end
      idle_inputs();
   endtask

   task automatic test_outstanding();
      int lds;
      apply_reset();
      bus.cl_valid = 1'b1;
      for (int i = 0; i < MAXO; i++) begin
         bus.cl_addr = 48'h8000 + 48'(i);
         #1;
         n_cmp++; if (bus.cl_ready !== 1'b1) begin n_bad++; $display("FAIL out_ready%0d got %b exp 1", i, bus.cl_ready); end
         tick();
         n_cmp++; if (bus.req_mem_ld !== 1'b1 || bus.req_mem_addr !== 48'h8000 + 48'(i)) begin n_bad++; $display("FAIL out_ld%0d got %b/%h exp 1/%h", i, bus.req_mem_ld, bus.req_mem_addr, 48'h8000 + 48'(i)); end
      end
      #1;
      n_cmp++; if (bus.cl_ready !== 1'b0 || bus.outstanding !== 6'd32) begin n_bad++; $display("FAIL out_full got %b/%0d exp 0/32", bus.cl_ready, bus.outstanding); end
      bus.rsp_mem_push = 1'b1;
      tick();
      bus.rsp_mem_push = 1'b0;
      n_cmp++; if (bus.outstanding !== 6'd31) begin n_bad++; $display("FAIL out_pop got %0d exp 31", bus.outstanding); end
      lds = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         lds += int'(bus.req_mem_ld);
      end
      n_cmp++; if (lds !== 1 || bus.outstanding !== 6'd32) begin n_bad++; $display("FAIL out_one_more got %0d lds/%0d exp 1/32", lds, bus.outstanding); end
      idle_inputs();
   endtask

   task automatic test_stall();
      apply_reset();
      load_window(48'h0, 48'h10000);
      bus.st_valid = 1'b1; bus.cl_valid = 1'b1; bus.dl_valid = 1'b1;
      bus.req_mem_stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++; if ({bus.st_ready, bus.cl_ready, bus.dl_ready} !== 3'b000) begin n_bad++; $display("FAIL stall_ready%0d got %b exp 000", i, {bus.st_ready, bus.cl_ready, bus.dl_ready}); end
         tick();
         n_cmp++; if ({bus.req_mem_ld, bus.req_mem_st} !== 2'b00) begin n_bad++; $display("FAIL stall_req%0d got %b exp 00", i, {bus.req_mem_ld, bus.req_mem_st}); end
      end
      bus.req_mem_stall = 1'b0;
      #1;
      n_cmp++; if (bus.st_ready !== 1'b1) begin n_bad++; $display("FAIL stall_resume got %b exp 1", bus.st_ready); end
      tick();
      n_cmp++; if (bus.req_mem_st !== 1'b1) begin n_bad++; $display("FAIL stall_resume_st got %b exp 1", bus.req_mem_st); end
      idle_inputs();
   endtask

   task automatic test_err_reset();
      apply_reset();
      bus.rsp_mem_push = 1'b1;
      tick();
      bus.rsp_mem_push = 1'b0;
      n_cmp++; if (bus.err !== 1'b1 || bus.outstanding !== 6'd0) begin n_bad++; $display("FAIL err_set got %b/%0d exp 1/0", bus.err, bus.outstanding); end
      tick();
      n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b exp 1", bus.err); end
      bus.cl_valid = 1'b1; bus.cl_addr = 48'h55;
      tick();
      bus.cl_valid = 1'b0;
      load_window(48'h4000, 48'h4100);
      bus.st_valid = 1'b1; bus.st_data = 64'h1234;
      tick();
      n_cmp++; if (bus.req_mem_st !== 1'b1 || bus.outstanding !== 6'd1) begin n_bad++; $display("FAIL burst_on got %b/%0d exp 1/1", bus.req_mem_st, bus.outstanding); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({bus.st_ready, bus.req_mem_ld, bus.req_mem_st, bus.done, bus.err} !== 5'b00000 || bus.outstanding !== 6'd0) begin n_bad++; $display("FAIL midreset got %b/%0d exp 00000/0", {bus.st_ready, bus.req_mem_ld, bus.req_mem_st, bus.done, bus.err}, bus.outstanding); end
      n_cmp++; if (bus.req_mem_addr !== 48'd0 || bus.req_mem_d_or_tag !== 64'd0) begin n_bad++; $display("FAIL midreset_bus got %h/%h exp 0/0", bus.req_mem_addr, bus.req_mem_d_or_tag); end
      tick();
      rst_n = 1'b1;
      #1;
      n_cmp++; if (bus.st_ready !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset got %b exp 0", bus.st_ready); end
      bus.st_valid = 1'b0; bus.rsp_mem_push = 1'b1;
      tick();
      bus.rsp_mem_push = 1'b0;
      n_cmp++; if (bus.err !== 1'b1 || bus.outstanding !== 6'd0) begin n_bad++; $display("FAIL err_after_reset got %b/%0d exp 1/0", bus.err, bus.outstanding); end
   endtask

   task automatic test_empty_window();
      apply_reset();
      bus.st_valid = 1'b1; bus.st_data = 64'hFEED;
      load_window(48'h2000, 48'h2000);
      n_cmp++; if (bus.done !== 1'b1 || bus.req_mem_st !== 1'b0) begin n_bad++; $display("FAIL empty_done got %b/%b exp 1/0", bus.done, bus.req_mem_st); end
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (bus.st_ready !== 1'b1) begin n_bad++; $display("FAIL empty_ready%0d got %b exp 1", i, bus.st_ready); end
         tick();
         n_cmp++; if (bus.req_mem_st !== 1'b0 || bus.done !== 1'b1) begin n_bad++; $display("FAIL empty_drop%0d got %b/%b exp 0/1", i, bus.req_mem_st, bus.done); end
      end
      idle_inputs();
   endtask

   function automatic int exp_winner();
      bit ld_ok;
      ld_ok = (m_q.size() < MAXO);
      if (bus.req_mem_stall) return 0;
      if (m_wait >= STARVE && bus.dl_valid && ld_ok) return 3;
      if (bus.st_valid && m_mode != 0 && !bus.cfg_load) return 1;
      if (bus.cl_valid && ld_ok) return 2;
      if (bus.dl_valid && ld_ok) return 3;
      return 0;
   endfunction

   task automatic model_update(input int w);
      m_ld = (w == 2) || (w == 3);
      m_st = (w == 1) && (m_mode == 1);
      if (w == 2) begin m_addr = bus.cl_addr; m_data = 64'd1; end
      else if (w == 3) begin m_addr = bus.dl_addr; m_data = {61'd0, bus.dl_tag, 1'b0}; end
      else if (m_st) begin m_addr = m_ptr; m_data = bus.st_data; end
      if (bus.cfg_load) begin
         m_ptr = bus.cfg_base; m_end = bus.cfg_end;
         m_mode = (bus.cfg_base == bus.cfg_end) ? 2 : 1;
      end else if (m_st) begin
         m_ptr = m_ptr + 48'd8;
         if (m_ptr == m_end) m_mode = 2;
      end
      if (bus.rsp_mem_push && m_q.size() == 0) m_err = 1'b1;
      if (bus.rsp_mem_push && m_ld) begin
         if (m_q.size() > 0) begin void'(m_q.pop_front()); m_q.push_back(w); end
      end else if (m_ld) m_q.push_back(w);
      else if (bus.rsp_mem_push && m_q.size() > 0) void'(m_q.pop_front());
      if (w == 3 || !bus.dl_valid) m_wait = 0;
      else if (!bus.req_mem_stall && m_wait < STARVE) m_wait++;
   endtask

   task automatic test_random();
      int w;
      apply_reset();
      m_mode = 0; m_ptr = 48'd0; m_end = 48'd0; m_wait = 0; m_q.delete();
      m_err = 1'b0; m_ld = 1'b0; m_st = 1'b0; m_addr = 48'd0; m_data = 64'd0;
      for (int c = 0; c < 800; c++) begin
         bus.st_valid      = ($urandom_range(0, 3) != 0);
         bus.st_data       = {$urandom, $urandom};
         bus.cl_valid      = ($urandom_range(0, 3) != 0);
         bus.cl_addr       = 48'($urandom);
         bus.dl_valid      = ($urandom_range(0, 7) != 0);
         bus.dl_addr       = 48'($urandom);
         bus.dl_tag        = 2'($urandom_range(0, 3));
         bus.req_mem_stall = ($urandom_range(0, 9) == 0);
         bus.rsp_mem_push  = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
         bus.cfg_load      = (c == 0) || ($urandom_range(0, 59) == 0);
         bus.cfg_base      = 48'h3000 + 48'($urandom_range(0, 31)) * 48'd8;
         bus.cfg_end       = bus.cfg_base + 48'($urandom_range(0, 5)) * 48'd8;
         #1;
         w = exp_winner();
         n_cmp++; if ({bus.st_ready, bus.cl_ready, bus.dl_ready} !== {w == 1, w == 2, w == 3}) begin n_bad++; $display("FAIL rnd_ready c%0d got %b exp %b", c, {bus.st_ready, bus.cl_ready, bus.dl_ready}, {w == 1, w == 2, w == 3}); end
         @(posedge clk);
         model_update(w);
         #1;
         n_cmp++; if ({bus.req_mem_ld, bus.req_mem_st} !== {m_ld, m_st}) begin n_bad++; $display("FAIL rnd_req c%0d got %b exp %b", c, {bus.req_mem_ld, bus.req_mem_st}, {m_ld, m_st}); end
         n_cmp++; if (bus.req_mem_addr !== m_addr || bus.req_mem_d_or_tag !== m_data) begin n_bad++; $display("FAIL rnd_bus c%0d got %h/%h exp %h/%h", c, bus.req_mem_addr, bus.req_mem_d_or_tag, m_addr, m_data); end
         n_cmp++; if (bus.done !== (m_mode == 2) || bus.err !== m_err || bus.outstanding !== 6'(m_q.size())) begin n_bad++; $display("FAIL rnd_status c%0d got %b/%b/%0d exp %b/%b/%0d", c, bus.done, bus.err, bus.outstanding, (m_mode == 2), m_err, m_q.size()); end
      end
      idle_inputs();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_store_window();
      test_starve();
      test_outstanding();
      test_stall();
      test_err_reset();
      test_empty_window();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout reached without completing the run");
      $fatal(1, "timeout");
   end
endmodule
